// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the control unit and the multiply/divide engine
//
// Signals:
//   start    - one-cycle operation request (accepted only when not busy)
//   op       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_in     - multiplicand / dividend
//   b_in     - multiplier / divisor
//   hi_we    - direct write of wdata into HI (MTHI)
//   lo_we    - direct write of wdata into LO (MTLO)
//   wdata    - data for HI/LO direct writes
//   busy     - operation in flight
//   done     - one-cycle completion pulse
//   div_zero - one-cycle pulse with done on a divide by zero
//   hi_out   - HI register
//   lo_out   - LO register
// master = control unit side, slave = engine side.

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multicycle multiply/divide engine owning the HI/LO registers
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - muldiv_unit_if.slave: start/op/a_in/b_in/hi_we/lo_we/wdata in,
//           busy/done/div_zero/hi_out/lo_out out
//
// Operations work on operand magnitudes (radix-2 shift-add multiply,
// restoring shift-subtract divide) and apply the result signs in a single
// fix-up cycle. A result is ready WIDTH+2 cycles after the start cycle.

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 neg_lo;     // product / quotient sign
    logic                 neg_hi;     // remainder sign
    logic [WIDTH-1:0]     opnd;       // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]   acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}

    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic                 accept;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a_in[WIDTH-1];
        b_neg     = op_signed & bus.b_in[WIDTH-1];
        // The most negative value maps onto itself, which read unsigned is its magnitude.
        a_abs     = a_neg ? -bus.a_in : bus.a_in;
        b_abs     = b_neg ? -bus.b_in : bus.b_in;
        // A new request is taken in IDLE and also in DONE so operations can run back-to-back.
        accept    = bus.start && ((state == IDLE) || (state == DONE));

        addend    = acc[0] ? opnd : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Shifted partial remainder minus divisor; bit WIDTH set means it did not fit.
        div_diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

        prod_fix  = neg_lo ? -acc : acc;
        quo_fix   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_div       <= 1'b0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            opnd         <= '0;
            acc          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi_out   <= '0;
            bus.lo_out   <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.hi_we) bus.hi_out <= bus.wdata;
                    if (bus.lo_we) bus.lo_out <= bus.wdata;
                end
                CALC: begin
                    if (is_div) begin
                        if (div_diff[WIDTH])
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        else
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        bus.hi_out <= rem_fix;
                        bus.lo_out <= quo_fix;
                    end else begin
                        bus.hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                        bus.lo_out <= prod_fix[WIDTH-1:0];
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed after the case so an accept in DONE overrides the return to IDLE.
            if (accept) begin
                is_div <= bus.op[1];
                neg_lo <= op_signed & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
                neg_hi <= op_signed & bus.a_in[WIDTH-1];
                if (bus.op[1] && (bus.b_in == '0)) begin
                    // HI/LO keep their values; only the flags report the fault.
                    state        <= DONE;
                    bus.done     <= 1'b1;
                    bus.div_zero <= 1'b1;
                end else begin
                    state    <= CALC;
                    bus.busy <= 1'b1;
                    cnt      <= CNT_W'(WIDTH);
                    if (bus.op[1]) begin
                        opnd <= b_abs;
                        acc  <= {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        opnd <= a_abs;
                        acc  <= {{WIDTH{1'b0}}, b_abs};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model

module tb_muldiv_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend, matching the architectural rule.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
        logic signed [63:0] sa, sb, sq, sr, sp;
        logic [63:0] up;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        dz = 1'b0;
        h  = m_hi;
        l  = m_lo;
        case (o)
            2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
            2'b10: begin
                if (b == 0) dz = 1'b1;
                else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin l = a / b; h = a % b; end
            end
        endcase
    endtask

    // Starts an operation in the current cycle (IDLE or DONE) and returns in the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit whi, input bit wlo, input logic [W-1:0] wd,
                         input bit disturb, input string tag);
        logic [W-1:0] eh, el, held_lo;
        bit dz;
        int lat, busy_cnt;
        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        model(o, a, b, eh, el, dz);
        bus.op = o; bus.a_in = a; bus.b_in = b;
        bus.hi_we = whi; bus.lo_we = wlo; bus.wdata = wd; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.op = 2'($urandom); bus.a_in = $urandom; bus.b_in = $urandom; bus.wdata = $urandom;
        lat = 1;
        busy_cnt = 0;
        held_lo = m_lo;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (disturb && lat == 11) chk({tag, "_lo_held"}, 64'(bus.lo_out), 64'(held_lo));
            bus.start = disturb && (lat == 5 || lat == 20);
            bus.lo_we = disturb && (lat == 10);
            tick();
            lat++;
        end
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        chk({tag, "_latency"}, 64'(lat), dz ? 64'd1 : 64'd34);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'd33);
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_div_zero"}, 64'(bus.div_zero), 64'(dz));
        chk({tag, "_hi"}, 64'(bus.hi_out), 64'(eh));
        chk({tag, "_lo"}, 64'(bus.lo_out), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic idle_tick(input string tag);
        tick();
        chk({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
        chk({tag, "_div_zero_end"}, 64'(bus.div_zero), 64'd0);
    endtask

    task automatic write_reg(input bit to_hi, input logic [W-1:0] wd, input string tag);
        bus.hi_we = to_hi; bus.lo_we = !to_hi; bus.wdata = wd;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        if (to_hi) begin m_hi = wd; chk(tag, 64'(bus.hi_out), 64'(wd)); end
        else       begin m_lo = wd; chk(tag, 64'(bus.lo_out), 64'(wd)); end
    endtask

    function automatic logic [W-1:0] pick_val();
        logic [W-1:0] edges [6];
        edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF; edges[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int done_seen;
        int gap;
        bit wh, wl;
        logic [W-1:0] wd;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a_in = '0; bus.b_in = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst_hi", 64'(bus.hi_out), 64'd0);
        chk("rst_lo", 64'(bus.lo_out), 64'd0);
        tick();

        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, '0, 0, "mult_neg3x5");
        chk("mult_neg3x5_hi_const", 64'(bus.hi_out), 64'hFFFF_FFFF);
        chk("mult_neg3x5_lo_const", 64'(bus.lo_out), 64'hFFFF_FFF1);
        idle_tick("mult_neg3x5");

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0, 0, "multu_max");
        chk("multu_max_hi_const", 64'(bus.hi_out), 64'hFFFF_FFFE);
        chk("multu_max_lo_const", 64'(bus.lo_out), 64'h0000_0001);
        idle_tick("multu_max");

        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, '0, 0, "div_neg7_2");
        chk("div_neg7_2_lo_const", 64'(bus.lo_out), 64'hFFFF_FFFD);
        chk("div_neg7_2_hi_const", 64'(bus.hi_out), 64'hFFFF_FFFF);
        idle_tick("div_neg7_2");

        do_op(2'b11, 32'd100, 32'd7, 0, 0, '0, 0, "divu_100_7");
        chk("divu_100_7_lo_const", 64'(bus.lo_out), 64'd14);
        chk("divu_100_7_hi_const", 64'(bus.hi_out), 64'd2);
        idle_tick("divu_100_7");

        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, '0, 0, "div_min_neg1");
        chk("div_min_neg1_lo_const", 64'(bus.lo_out), 64'h8000_0000);
        chk("div_min_neg1_hi_const", 64'(bus.hi_out), 64'd0);
        idle_tick("div_min_neg1");

        write_reg(1, 32'h1111_1111, "preload_hi");
        write_reg(0, 32'h2222_2222, "preload_lo");
        do_op(2'b10, 32'd1234, 32'd0, 0, 0, '0, 0, "div_by_zero");
        chk("div_by_zero_hi_const", 64'(bus.hi_out), 64'h1111_1111);
        chk("div_by_zero_lo_const", 64'(bus.lo_out), 64'h2222_2222);
        idle_tick("div_by_zero");

        write_reg(1, 32'hCAFE_F00D, "mthi_idle");

        // Ignored starts and LO write while busy, then a start in the done cycle.
        do_op(2'b00, 32'h0001_2345, 32'hFFFF_FF00, 0, 0, '0, 1, "mult_disturbed");
        do_op(2'b01, 32'h89AB_CDEF, 32'h0000_1003, 0, 0, '0, 0, "back_to_back");
        idle_tick("back_to_back");

        // Write and start in the same IDLE cycle: the write lands, divide-by-zero keeps it.
        do_op(2'b11, 32'd55, 32'd0, 1, 0, 32'hA5A5_0F0F, 0, "start_with_mthi");
        idle_tick("start_with_mthi");

        for (int i = 0; i < 24; i++) begin
            gap = $urandom_range(0, 2);
            wh = 1'b0;
            wl = 1'b0;
            wd = $urandom;
            for (int g = 0; g < gap; g++) idle_tick($sformatf("rnd%0d_gap", i));
            if (gap > 0) begin
                wh = 1'($urandom);
                wl = 1'($urandom);
            end
            do_op(2'($urandom), pick_val(), pick_val(), wh, wl, wd, 0, $sformatf("rnd%0d", i));
        end
        idle_tick("rnd_end");

        // Reset in the middle of a DIVU abandons it without a done pulse.
        bus.op = 2'b11; bus.a_in = 32'hDEAD_BEEF; bus.b_in = 32'd13; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hi", 64'(bus.hi_out), 64'd0);
        chk("midrst_lo", 64'(bus.lo_out), 64'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done !== 1'b0) done_seen++;
            tick();
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
